// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (DM) ports; one access in flight, ready at t+2+MEM_LAT.
// Requesters hold req until their one-cycle ready pulse; DM has priority but IF is forced after STARVE_MAX DM wins.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              own_dm;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic [CNT_W-1:0]  cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              any_req;
  logic              grant_dm;
  logic              last_wait;

  assign any_req   = if_req | dm_req;
  // IF wins a tie only once DM has taken STARVE_MAX consecutive grants over it.
  assign grant_dm  = dm_req & (~if_req | (starve_cnt != SC_W'(STARVE_MAX)));
  assign last_wait = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (last_wait) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    busy      = (state != IDLE);
    if (state == ACCESS) begin
      mem_en = 1'b1;
      mem_we = lat_we;
      mem_be = lat_we ? lat_be : '1;
    end
    if (state == DONE) begin
      if_ready = ~own_dm;
      dm_ready = own_dm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_dm     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      cnt        <= '0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          own_dm    <= grant_dm;
          lat_we    <= grant_dm & dm_we;
          lat_addr  <= grant_dm ? dm_addr : if_addr;
          lat_wdata <= dm_wdata;
          lat_be    <= dm_be;
          if (grant_dm && if_req) begin
            if (starve_cnt != SC_W'(STARVE_MAX)) starve_cnt <= starve_cnt + SC_W'(1);
          end else begin
            starve_cnt <= '0;
          end
        end
        ACCESS: cnt <= CNT_W'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          // Stores never touch the load data register.
          if (last_wait) begin
            if (!own_dm)     if_rdata <= mem_rdata;
            else if (!lat_we) dm_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: expected accesses/responses are queued at issue time and checked by monitors.
module tb_unified_mem_arbiter;
  typedef struct { bit dm; logic [31:0] dat; int cyc; } rsp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int cyc; } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with MEM_LAT=1, STARVE_MAX=2
  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [3:0]  dm_be = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we, busy;
  logic [3:0]  mem_be;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  // DUT with MEM_LAT=3
  logic        d3_if_req = 0, d3_dm_req = 0, d3_dm_we = 0;
  logic [31:0] d3_if_addr = 0, d3_dm_addr = 0, d3_dm_wdata = 0;
  logic [3:0]  d3_dm_be = 0;
  logic [31:0] d3_if_rdata, d3_dm_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;
  logic        d3_if_ready, d3_dm_ready, d3_mem_en, d3_mem_we, d3_busy;
  logic [3:0]  d3_mem_be;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(d3_if_req), .if_addr(d3_if_addr), .if_rdata(d3_if_rdata), .if_ready(d3_if_ready),
    .dm_req(d3_dm_req), .dm_we(d3_dm_we), .dm_addr(d3_dm_addr), .dm_wdata(d3_dm_wdata), .dm_be(d3_dm_be),
    .dm_rdata(d3_dm_rdata), .dm_ready(d3_dm_ready),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
    .mem_be(d3_mem_be), .mem_rdata(d3_mem_rdata), .busy(d3_busy)
  );

  // Memory model, 1-cycle latency; data outside the valid cycle is poisoned.
  logic [31:0] mem [0:1023];
  logic        rd_vld = 0;
  logic [31:0] rd_dat = 0;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[4]   = 32'h00500093;
    mem[128] = 32'h11223344;
  end
  always @(posedge clk) begin
    rd_vld <= mem_en & ~mem_we;
    rd_dat <= mem[mem_addr[11:2]];
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end
  assign mem_rdata = rd_vld ? rd_dat : 32'hBAD0BAD0;

  // Memory model, 3-cycle latency; read data = addr ^ A5A5A5A5.
  logic [2:0]  p_vld = 0;
  logic [31:0] p_dat [0:2];
  always @(posedge clk) begin
    p_vld    <= {p_vld[1:0], d3_mem_en & ~d3_mem_we};
    p_dat[0] <= d3_mem_addr ^ 32'hA5A5A5A5;
    p_dat[1] <= p_dat[0];
    p_dat[2] <= p_dat[1];
  end
  assign d3_mem_rdata = p_vld[2] ? p_dat[2] : 32'hBAD0BAD0;

  rsp_t rsp_q[$], rsp3_q[$];
  acc_t acc_q[$], acc3_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  task automatic exp_acc(bit d3, bit we, logic [31:0] a, logic [31:0] w, logic [3:0] be, int c);
    acc_t e;
    e = '{we, a, w, be, c};
    if (d3) acc3_q.push_back(e); else acc_q.push_back(e);
  endtask

  task automatic exp_rsp(bit d3, bit dm, logic [31:0] d, int c);
    rsp_t e;
    e = '{dm, d, c};
    if (d3) rsp3_q.push_back(e); else rsp_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    if (mem_en) begin
      if (acc_q.size() == 0) fail("acc_unexpected");
      else begin
        a = acc_q.pop_front();
        chk("acc_cycle", cyc, a.cyc);
        chk("acc_we", {31'b0, mem_we}, {31'b0, a.we});
        chk("acc_addr", mem_addr, a.addr);
        chk("acc_be", {28'b0, mem_be}, {28'b0, a.be});
        if (a.we) chk("acc_wdata", mem_wdata, a.wdata);
      end
    end
    if (if_ready || dm_ready) begin
      if (rsp_q.size() == 0) fail("rsp_unexpected");
      else begin
        r = rsp_q.pop_front();
        chk("rsp_both", {31'b0, if_ready & dm_ready}, 32'd0);
        chk("rsp_port_dm", {31'b0, dm_ready}, {31'b0, r.dm});
        chk("rsp_cycle", cyc, r.cyc);
        chk("rsp_rdata", r.dm ? dm_rdata : if_rdata, r.dat);
      end
    end
  end

  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    if (d3_mem_en) begin
      if (acc3_q.size() == 0) fail("d3_acc_unexpected");
      else begin
        a = acc3_q.pop_front();
        chk("d3_acc_cycle", cyc, a.cyc);
        chk("d3_acc_addr", d3_mem_addr, a.addr);
        chk("d3_acc_be", {28'b0, d3_mem_be}, {28'b0, a.be});
      end
    end
    if (d3_if_ready || d3_dm_ready) begin
      if (rsp3_q.size() == 0) fail("d3_rsp_unexpected");
      else begin
        r = rsp3_q.pop_front();
        chk("d3_rsp_port_dm", {31'b0, d3_dm_ready}, {31'b0, r.dm});
        chk("d3_rsp_cycle", cyc, r.cyc);
        chk("d3_rsp_rdata", r.dm ? d3_dm_rdata : d3_if_rdata, r.dat);
      end
    end
  end

  initial begin
    int t;
    step(3);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_be", {28'b0, mem_be}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_readies", {30'b0, if_ready, dm_ready}, 0);
    rst = 0;
    step(1);

    // Single fetch
    t = cyc;
    if_req = 1; if_addr = 32'h10;
    exp_acc(0, 0, 32'h10, 0, 4'hF, t + 1);
    exp_rsp(0, 0, 32'h00500093, t + 3);
    step(1);
    chk("t1_busy_access", {31'b0, busy}, 1);
    step(3);
    if_req = 0;
    chk("t1_busy_after", {31'b0, busy}, 0);

    // Simultaneous IF and DM load: DM first
    step(1);
    t = cyc;
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    exp_acc(0, 0, 32'h100, 0, 4'hF, t + 1);
    exp_rsp(0, 1, 32'hC0DE0040, t + 3);
    exp_acc(0, 0, 32'h20, 0, 4'hF, t + 5);
    exp_rsp(0, 0, 32'hC0DE0008, t + 7);
    step(4);
    dm_req = 0;
    step(4);
    if_req = 0;

    // Starvation: both held, grant order DM, DM, IF, DM, DM, IF
    step(1);
    t = cyc;
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      bit is_dm;
      is_dm = (k % 3) != 2;
      exp_acc(0, 0, is_dm ? 32'h100 : 32'h20, 0, 4'hF, t + 1 + 4 * k);
      exp_rsp(0, is_dm, is_dm ? 32'hC0DE0040 : 32'hC0DE0008, t + 3 + 4 * k);
    end
    step(24);
    if_req = 0; dm_req = 0;

    // Partial store, then load back the merged word
    step(1);
    t = cyc;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    exp_acc(0, 1, 32'h200, 32'hDEADBEEF, 4'b0011, t + 1);
    exp_rsp(0, 1, 32'hC0DE0040, t + 3);
    step(4);
    dm_we = 0; dm_be = 4'b0000;
    exp_acc(0, 0, 32'h200, 0, 4'hF, t + 5);
    exp_rsp(0, 1, 32'h1122BEEF, t + 7);
    step(4);
    dm_req = 0;

    // Reset during WAIT aborts the fetch
    step(1);
    t = cyc;
    if_req = 1; if_addr = 32'h30;
    exp_acc(0, 0, 32'h30, 0, 4'hF, t + 1);
    step(2);
    rst = 1; if_req = 0;
    step(1);
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_mem_en", {31'b0, mem_en}, 0);
    chk("t5_readies", {30'b0, if_ready, dm_ready}, 0);
    chk("t5_if_rdata", if_rdata, 0);
    chk("t5_dm_rdata", dm_rdata, 0);
    rst = 0;
    step(1);
    t = cyc;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    exp_acc(0, 0, 32'h100, 0, 4'hF, t + 1);
    exp_rsp(0, 1, 32'hC0DE0040, t + 3);
    step(4);
    dm_req = 0;

    // MEM_LAT=3: load then fetch
    step(1);
    t = cyc;
    d3_dm_req = 1; d3_dm_we = 0; d3_dm_addr = 32'h40;
    exp_acc(1, 0, 32'h40, 0, 4'hF, t + 1);
    exp_rsp(1, 1, 32'hA5A5A5E5, t + 5);
    step(6);
    d3_dm_req = 0;
    t = cyc;
    d3_if_req = 1; d3_if_addr = 32'h44;
    exp_acc(1, 0, 32'h44, 0, 4'hF, t + 1);
    exp_rsp(1, 0, 32'hA5A5A5E1, t + 5);
    step(6);
    d3_if_req = 0;

    step(3);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("d3_acc_q_drained", acc3_q.size(), 0);
    chk("d3_rsp_q_drained", rsp3_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
